// File: rtl/mod_mul_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// mod_mul_issue_ctrl_if
//   Operand/result handshake bundle for the modular-multiplier issue controller.
//
//   in_valid / in_ready / in_a / in_b : operand-pair stream into the controller
//   out_valid / out_ready / out_c     : result stream out of the controller
//
//   Modports:
//     master : environment side (drives operands, consumes results)
//     slave  : controller side  (accepts operands, presents results)
// -----------------------------------------------------------------------------
interface mod_mul_issue_ctrl_if #(
    parameter int Q_LEN = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [Q_LEN-1:0] in_a;
    logic [Q_LEN-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [Q_LEN-1:0] out_c;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c
    );
endinterface

// File: rtl/mod_mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mod_mul_issue_ctrl
//   Valid/ready front end for a fixed-latency, never-stalling modular multiplier.
//   Operand pairs are registered into the multiplier, a valid shift register
//   tracks each op through the pipe, and results are caught in a show-ahead
//   FIFO. Because the multiplier cannot be stalled, an op is only launched when
//   a FIFO slot is already reserved for it (credit = inflight + fifo count).
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   cfg_q     in   modulus, loaded into mm_q only while nothing is in flight
//   bus       slave modport: in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_c
//   mm_a      out  registered operand A to the multiplier
//   mm_b      out  registered operand B to the multiplier
//   mm_q      out  registered modulus to the multiplier
//   mm_c      in   multiplier result, valid when the tracking bit reaches the end
//   inflight  out  ops issued but not yet written into the FIFO
//   idle      out  nothing in flight and FIFO empty
// -----------------------------------------------------------------------------
module mod_mul_issue_ctrl #(
    parameter int Q_LEN      = 64,
    parameter int LATENCY    = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Q_LEN-1:0]                 cfg_q,
    mod_mul_issue_ctrl_if.slave              bus,
    output logic [Q_LEN-1:0]                 mm_a,
    output logic [Q_LEN-1:0]                 mm_b,
    output logic [Q_LEN-1:0]                 mm_q,
    input  logic [Q_LEN-1:0]                 mm_c,
    output logic [$clog2(LATENCY+1)-1:0]     inflight,
    output logic                             idle
);

    localparam int IW = $clog2(LATENCY + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Credit sum is one bit wider than the count so it can never wrap.
    localparam int SW = AW + 2;
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic               rst_released;
    logic               ready;
    logic               fire;
    logic               retire;
    logic               push;
    logic               pop;
    logic               fifo_valid;
    logic [LATENCY-1:0] vld_sr;
    logic [SW-1:0]      credit_used;

    logic [Q_LEN-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    // Ready depends only on registered state: a pop in this cycle frees its
    // credit one cycle later, which keeps in_ready free of any comb path from
    // out_ready.
    assign credit_used = SW'(inflight) + SW'(count);
    assign ready       = rst_released & (credit_used < DEPTH_S);
    assign fire        = bus.in_valid & ready;
    assign retire      = vld_sr[LATENCY-1];
    assign push        = retire;
    assign fifo_valid  = (count != '0);
    assign pop         = fifo_valid & bus.out_ready;

    assign bus.in_ready  = ready;
    assign bus.out_valid = fifo_valid;
    // Show-ahead head; forced to zero when empty so no stale entry is visible.
    assign bus.out_c     = fifo_valid ? mem[rd_ptr] : '0;

    assign idle = (inflight == '0) && (count == '0);

    // ---- issue stage: operands, modulus and tracking register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_released <= 1'b0;
            mm_a         <= '0;
            mm_b         <= '0;
            mm_q         <= '0;
            vld_sr       <= '0;
            inflight     <= '0;
        end else begin
            rst_released <= 1'b1;
            if (fire) begin
                mm_a <= bus.in_a;
                mm_b <= bus.in_b;
            end
            // Modulus may only change with an empty pipe, so every op in
            // flight is computed against the same q it was issued with.
            if (inflight == '0) begin
                mm_q <= cfg_q;
            end
            vld_sr <= (vld_sr << 1) | LATENCY'(fire);
            unique case ({fire, retire})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // ---- retire stage: result capture into the FIFO ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= mm_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The credit scheme reserves a slot before launch, so a retiring result
    // must always find room.
    assert property (@(posedge clk) disable iff (!rst) push |-> (count < DEPTH_C));

endmodule

// File: tb/tb_mod_mul_issue_ctrl.sv
module tb_mod_mul_issue_ctrl;
    localparam int Q_LEN = 64;
    localparam int LAT   = 10;
    localparam int DEPTH = 16;
    localparam int IW    = $clog2(LAT + 1);
    localparam logic [63:0] Q61 = 64'h1FFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   cfg_q;
    logic [63:0]   mm_a, mm_b, mm_q, mm_c;
    logic [IW-1:0] inflight;
    logic          idle;

    int n_pass = 0;
    int n_chk  = 0;

    // (3+i)*4 mod 7 for i = 0..4
    logic [63:0] exp5 [5] = '{64'd5, 64'd2, 64'd6, 64'd3, 64'd0};

    mod_mul_issue_ctrl_if #(.Q_LEN(Q_LEN)) bus ();

    mod_mul_issue_ctrl #(
        .Q_LEN(Q_LEN), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_q(cfg_q), .bus(bus),
        .mm_a(mm_a), .mm_b(mm_b), .mm_q(mm_q), .mm_c(mm_c),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // Multiplier model: mm_a/mm_b/mm_q are the first register of the path,
    // followed by LAT-1 further stages, so mm_c lines up with the last
    // tracking bit.
    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q);
        logic [127:0] p;
        if (q == 64'd0) return 64'd0;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, q});
    endfunction

    logic [63:0] mpipe [LAT-1];
    always_ff @(posedge clk) begin
        mpipe[0] <= mulmod(mm_a, mm_b, mm_q);
        for (int i = 1; i < LAT - 1; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mm_c = mpipe[LAT-2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0h expected 0", bus.in_ready); else n_pass++;
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0h expected 0", bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_c !== 64'd0) $display("FAIL reset_out_c: got %0h expected 0", bus.out_c); else n_pass++;
        n_chk++; if (inflight !== '0) $display("FAIL reset_inflight: got %0d expected 0", inflight); else n_pass++;
        n_chk++; if (idle !== 1'b1) $display("FAIL reset_idle: got %0h expected 1", idle); else n_pass++;
        n_chk++; if (mm_q !== 64'd0) $display("FAIL reset_mm_q: got %0h expected 0", mm_q); else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %0h expected 1", bus.in_ready); else n_pass++;
        n_chk++; if (mm_q !== 64'd7) $display("FAIL release_mm_q: got %0d expected 7", mm_q); else n_pass++;
    endtask

    task automatic test_single();
        int cyc;
        bus.in_a = 64'd3; bus.in_b = 64'd5; bus.in_valid = 1'b1;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL single_ready: got %0h expected 1", bus.in_ready); else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_chk++; if (inflight !== IW'(1)) $display("FAIL single_inflight: got %0d expected 1", inflight); else n_pass++;
        n_chk++; if (mm_a !== 64'd3 || mm_b !== 64'd5) $display("FAIL single_mm_ab: got %0d,%0d expected 3,5", mm_a, mm_b); else n_pass++;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        n_chk++; if (cyc != LAT + 1) $display("FAIL single_latency: got %0d expected %0d", cyc, LAT + 1); else n_pass++;
        n_chk++; if (bus.out_c !== 64'd1) $display("FAIL single_out_c: got %0d expected 1", bus.out_c); else n_pass++;
        n_chk++; if (inflight !== '0 || idle !== 1'b0) $display("FAIL single_retired: got inflight=%0d idle=%0h expected 0,0", inflight, idle); else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_chk++; if (bus.out_valid !== 1'b0 || idle !== 1'b1) $display("FAIL single_after_pop: got valid=%0h idle=%0h expected 0,1", bus.out_valid, idle); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int issued, got, ready_low, bad, bubbles, cyc;
        logic [63:0] exp;
        cfg_q = Q61;
        tick();
        bus.out_ready = 1'b1;
        issued = 0; got = 0; ready_low = 0; bad = 0; bubbles = 0; cyc = 0;
        while (got < 64 && cyc < 300) begin
            bus.in_valid = (issued < 64);
            bus.in_a = 64'(issued);
            bus.in_b = 64'(issued + 1);
            if (issued < 64) begin
                if (bus.in_ready !== 1'b1) ready_low++;
                else issued++;
            end
            if (bus.out_valid === 1'b1) begin
                exp = 64'(got) * 64'(got + 1);
                if (bus.out_c !== exp) bad++;
                got++;
            end else if (got > 0) begin
                bubbles++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        n_chk++; if (ready_low != 0) $display("FAIL b2b_ready_low: got %0d expected 0", ready_low); else n_pass++;
        n_chk++; if (got != 64 || issued != 64) $display("FAIL b2b_count: got %0d/%0d expected 64/64", got, issued); else n_pass++;
        n_chk++; if (bad != 0) $display("FAIL b2b_data: got %0d bad expected 0", bad); else n_pass++;
        n_chk++; if (bubbles != 0) $display("FAIL b2b_bubbles: got %0d expected 0", bubbles); else n_pass++;
        n_chk++; if (idle !== 1'b1) $display("FAIL b2b_idle: got %0h expected 1", idle); else n_pass++;
    endtask

    task automatic test_backpressure();
        int fires, popped, bad;
        bus.out_ready = 1'b0;
        fires = 0;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 64'(fires + 1);
            bus.in_b = 64'd3;
            if (bus.in_ready === 1'b1) fires++;
            tick();
        end
        bus.in_valid = 1'b0;
        n_chk++; if (fires != DEPTH) $display("FAIL bp_fires: got %0d expected %0d", fires, DEPTH); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_full: got %0h expected 0", bus.in_ready); else n_pass++;
        n_chk++; if (inflight !== '0 || bus.out_valid !== 1'b1) $display("FAIL bp_full_state: got inflight=%0d valid=%0h expected 0,1", inflight, bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_c !== 64'd3) $display("FAIL bp_head: got %0d expected 3", bus.out_c); else n_pass++;
        bus.out_ready = 1'b1;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_pop_cycle: got %0h expected 0", bus.in_ready); else n_pass++;
        tick();
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %0h expected 1", bus.in_ready); else n_pass++;
        popped = 1; bad = 0;
        while (bus.out_valid === 1'b1 && popped < 20) begin
            if (bus.out_c !== 64'(3 * (popped + 1))) bad++;
            popped++;
            tick();
        end
        bus.out_ready = 1'b0;
        n_chk++; if (popped != DEPTH || bad != 0) $display("FAIL bp_drain: got %0d pops %0d bad expected %0d pops 0 bad", popped, bad, DEPTH); else n_pass++;
        n_chk++; if (idle !== 1'b1) $display("FAIL bp_idle: got %0h expected 1", idle); else n_pass++;
    endtask

    task automatic test_fire_pop_same_cycle();
        int fires, cyc, popped, bad;
        logic [63:0] exp;
        fires = 0; cyc = 0;
        while (fires < 15 && cyc < 60) begin
            bus.in_valid = 1'b1;
            bus.in_a = 64'(100 + fires);
            bus.in_b = 64'd1;
            if (bus.in_ready === 1'b1) fires++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (inflight !== '0 && cyc < 40) begin tick(); cyc++; end
        n_chk++; if (fires != 15 || bus.in_ready !== 1'b1 || bus.out_c !== 64'd100) $display("FAIL fp_setup: got fires=%0d ready=%0h head=%0d expected 15,1,100", fires, bus.in_ready, bus.out_c); else n_pass++;
        bus.in_valid = 1'b1; bus.in_a = 64'd200; bus.in_b = 64'd1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL fp_ready_next: got %0h expected 1", bus.in_ready); else n_pass++;
        n_chk++; if (inflight !== IW'(1) || bus.out_c !== 64'd101) $display("FAIL fp_state: got inflight=%0d head=%0d expected 1,101", inflight, bus.out_c); else n_pass++;
        cyc = 0;
        while (inflight !== '0 && cyc < 40) begin tick(); cyc++; end
        bus.out_ready = 1'b1;
        popped = 0; bad = 0;
        while (bus.out_valid === 1'b1 && popped < 20) begin
            exp = (popped < 14) ? 64'(101 + popped) : 64'd200;
            if (bus.out_c !== exp) bad++;
            popped++;
            tick();
        end
        bus.out_ready = 1'b0;
        n_chk++; if (popped != 15 || bad != 0) $display("FAIL fp_drain: got %0d pops %0d bad expected 15 pops 0 bad", popped, bad); else n_pass++;
    endtask

    task automatic test_cfg_change();
        int fires, cyc, got, bad, held_bad, zc;
        logic [63:0] mq_after;
        cfg_q = 64'd7;
        tick(); tick();
        n_chk++; if (mm_q !== 64'd7) $display("FAIL cfg_load: got %0d expected 7", mm_q); else n_pass++;
        bus.out_ready = 1'b1;
        fires = 0; cyc = 0;
        while (fires < 5 && cyc < 20) begin
            bus.in_valid = 1'b1;
            bus.in_a = 64'(fires + 3);
            bus.in_b = 64'd4;
            if (bus.in_ready === 1'b1) fires++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_chk++; if (inflight !== IW'(5)) $display("FAIL cfg_inflight5: got %0d expected 5", inflight); else n_pass++;
        cfg_q = 64'd13;
        got = 0; bad = 0; held_bad = 0; zc = -1; mq_after = 64'd0;
        for (int c = 0; c < 20; c++) begin
            if (zc < 0 && inflight === '0) zc = c;
            if (zc < 0 || c == zc) begin
                if (mm_q !== 64'd7) held_bad++;
            end
            if (zc >= 0 && c == zc + 1) mq_after = mm_q;
            if (bus.out_valid === 1'b1) begin
                if (got < 5 && bus.out_c !== exp5[got]) bad++;
                got++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_chk++; if (held_bad != 0) $display("FAIL cfg_held: got %0d early changes expected 0", held_bad); else n_pass++;
        n_chk++; if (got != 5 || bad != 0) $display("FAIL cfg_results: got %0d results %0d bad expected 5,0", got, bad); else n_pass++;
        n_chk++; if (zc < 0 || mq_after !== 64'd13) $display("FAIL cfg_new_q: got %0d expected 13", mq_after); else n_pass++;
    endtask

    task automatic test_async_reset();
        int fires, cyc, stale;
        bus.out_ready = 1'b0;
        fires = 0; cyc = 0;
        while (fires < 3 && cyc < 20) begin
            bus.in_valid = 1'b1; bus.in_a = 64'(fires + 1); bus.in_b = 64'd1;
            if (bus.in_ready === 1'b1) fires++;
            tick(); cyc++;
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (inflight !== '0 && cyc < 40) begin tick(); cyc++; end
        fires = 0; cyc = 0;
        while (fires < 4 && cyc < 20) begin
            bus.in_valid = 1'b1; bus.in_a = 64'(fires + 5); bus.in_b = 64'd1;
            if (bus.in_ready === 1'b1) fires++;
            tick(); cyc++;
        end
        bus.in_valid = 1'b0;
        n_chk++; if (inflight !== IW'(4) || bus.out_valid !== 1'b1) $display("FAIL ar_setup: got inflight=%0d valid=%0h expected 4,1", inflight, bus.out_valid); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_chk++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL ar_handshake: got ready=%0h valid=%0h expected 0,0", bus.in_ready, bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_c !== 64'd0 || inflight !== '0 || idle !== 1'b1) $display("FAIL ar_state: got out_c=%0h inflight=%0d idle=%0h expected 0,0,1", bus.out_c, inflight, idle); else n_pass++;
        n_chk++; if (mm_a !== 64'd0 || mm_q !== 64'd0) $display("FAIL ar_mm: got a=%0h q=%0h expected 0,0", mm_a, mm_q); else n_pass++;
        tick(); tick();
        rst = 1'b1;
        tick();
        n_chk++; if (bus.in_ready !== 1'b1 || idle !== 1'b1) $display("FAIL ar_release: got ready=%0h idle=%0h expected 1,1", bus.in_ready, idle); else n_pass++;
        stale = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.out_valid !== 1'b0 || inflight !== '0) stale++;
            tick();
        end
        n_chk++; if (stale != 0) $display("FAIL ar_stale: got %0d stale cycles expected 0", stale); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        cfg_q = 64'd7;
        bus.in_valid = 1'b0;
        bus.in_a = 64'd0;
        bus.in_b = 64'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fire_pop_same_cycle();
        test_cfg_change();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
